itcm_ctrl: RTL
==============

Name: itcm_ctrl

Overview:
- Responder side of the instruction fetch ITCM interface; answers fetch requests with one-cycle-latency reads from a single-port ITCM SRAM macro.
- After reset it optionally auto-loads the ITCM image from external memory through a simple request/valid load port.
- During the auto-load it asserts `itcm_auto_load` to the fetch controller, which masks fetch data while the flag is high.

Parameters:
- ADDR_WIDTH, 32, width of fetch and load addresses.
- DATA_WIDTH, 32, instruction / SRAM word width. Fixed at 32.
- DEPTH_LOG2, 12, log2 of ITCM depth in words (default 4096 words = 16 KB).
- LOAD_WORDS, 4096, number of words copied by auto-load. Must satisfy 1 <= LOAD_WORDS <= 2^DEPTH_LOG2.
- LOAD_SRC_BASE, 32'h0000_0000, byte address of the image in external memory.

Ports:
- cpu_clk, in, 1, CPU clock.
- cpu_rstn, in, 1, reset, asynchronous, active-low.
- instr_itcm_access, in, 1, fetch request (level, sampled every cycle).
- instr_itcm_addr, in, ADDR_WIDTH, fetch byte address (word-aligned).
- instr_itcm_read_data, out, DATA_WIDTH, instruction returned.
- instr_itcm_read_data_valid, out, 1, read data valid.
- itcm_auto_load, out, 1, auto-load in progress.
- ld_req, out, 1, load-port read request.
- ld_addr, out, ADDR_WIDTH, load-port byte address.
- ld_rdata, in, DATA_WIDTH, load-port read data.
- ld_rvalid, in, 1, load-port data valid; completes the current request.
- sram_ce, out, 1, SRAM chip enable.
- sram_we, out, 1, SRAM write enable.
- sram_addr, out, DEPTH_LOG2, SRAM word address.
- sram_wdata, out, DATA_WIDTH, SRAM write data.
- sram_rdata, in, DATA_WIDTH, SRAM read data, valid the cycle after a read with `sram_ce` high.

Behaviour:

Reset values:
- With the feature enabled: state = LOAD, `itcm_auto_load` = 1, load counter `cnt` = 0, `instr_itcm_read_data_valid` = 0.
- All combinational outputs are 0 in reset, except `ld_req` and `ld_addr`, which follow the LOAD state.

State machine (2 states):
- LOAD:
  - `ld_req` = 1 and `ld_addr` = LOAD_SRC_BASE + 4*cnt. Both hold stable until `ld_rvalid`.
  - On `ld_rvalid`, the same cycle: `sram_ce` = 1, `sram_we` = 1, `sram_addr` = cnt[DEPTH_LOG2-1:0], `sram_wdata` = `ld_rdata`.
  - If cnt == LOAD_WORDS-1: go to SERVE and clear `itcm_auto_load` (registered). Otherwise cnt <= cnt+1 and stay in LOAD.
  - `ld_req` may remain high across back-to-back words; the address advances the cycle after each `ld_rvalid`.
- SERVE:
  - `ld_req` = 0.
  - When `instr_itcm_access` = 1: `sram_ce` = 1, `sram_we` = 0, `sram_addr` = `instr_itcm_addr`[DEPTH_LOG2+1:2].
  - `instr_itcm_read_data_valid` is registered: it equals the previous cycle's accepted access.
  - `instr_itcm_read_data` = `sram_rdata` when valid, else 0.
  - Latency is exactly 1 cycle, one access per cycle, no stalls.
  - SERVE is terminal until reset.

Boundary rules:
- Fetch accesses during LOAD are ignored: no SRAM read and valid stays 0.
- `ld_rvalid` in SERVE is ignored.
- `instr_itcm_addr`[1:0] is ignored (aligned only). Address bits above DEPTH_LOG2+1 are ignored; decode is the requester's job.
- The cycle the last word is written, `itcm_auto_load` is still 1. It reads 0 the next cycle, and that same cycle a fetch may be accepted.
- Reset mid-load aborts the load. After release the load restarts at cnt = 0 with `itcm_auto_load` = 1.
- `cnt` width is DEPTH_LOG2+1 bits; it never wraps because the FSM leaves LOAD at LOAD_WORDS-1.

Optional Feature:
- Macro: KRV_ITCM_AUTO_LOAD_EN.
- Defined: auto-load behaves as described above.
- Undefined:
  - Reset state is SERVE.
  - `itcm_auto_load` is tied 0; `ld_req` and `ld_addr` are tied 0.
  - The `cnt` register and the load write path are not generated.
  - Fetches are served from the first cycle after reset release.

Test Plan:
1. Feature on, LOAD_WORDS=4, LOAD_SRC_BASE=32'h1000, `ld_rvalid` 2 cycles after each request with data 32'hA0..A3 -> `ld_addr` sequence 1000/1004/1008/100C; SRAM writes to addr 0..3; `itcm_auto_load` falls the cycle after the 4th `ld_rvalid`.
2. After load, access addr 32'h8 -> `instr_itcm_read_data_valid` = 1 with data 32'hA2 exactly 1 cycle later. Back-to-back accesses 0,4,C -> valid on 3 consecutive cycles with data A0, A1, A3.
3. Assert `instr_itcm_access` during LOAD -> `sram_we` is not disturbed, no read is issued, `instr_itcm_read_data_valid` stays 0.
4. Assert `cpu_rstn` low after 2 of 4 words, then release -> `itcm_auto_load` = 1 and `ld_addr` = 32'h1000 again; the full 4-word load completes.
5. Feature off -> `itcm_auto_load` = 0 and `ld_req` = 0 from reset; access addr 0 in the first cycle after reset yields valid 1 cycle later.
6. `ld_rvalid` pulsed in SERVE with data 32'hDEAD -> no SRAM write; a subsequent read of addr 0 still returns 32'hA0.

Source files
------------

// File: rtl/itcm_ctrl.sv
// -----------------------------------------------------------------------------
// itcm_ctrl
//
// Responder side of the instruction-fetch ITCM interface. Fetch requests are
// answered with a fixed one-cycle read from a single-port SRAM macro.
//
// Optional feature (macro KRV_ITCM_AUTO_LOAD_EN):
//   Defined   - after reset the ITCM image (LOAD_WORDS words) is copied from
//               external memory at LOAD_SRC_BASE through the ld_* port. While
//               the copy runs, itcm_auto_load is high and fetches are ignored.
//   Undefined - no load path. Fetches are served from the first cycle after
//               reset release. itcm_auto_load, ld_req and ld_addr are tied 0.
//
// Ports:
//   cpu_clk, cpu_rstn            clock, asynchronous active-low reset
//   instr_itcm_access/_addr      fetch request (level) and word-aligned byte address
//   instr_itcm_read_data(_valid) fetch data, valid exactly one cycle after accept
//   itcm_auto_load               auto-load in progress
//   ld_req, ld_addr              load-port read request and byte address
//   ld_rdata, ld_rvalid          load-port data; ld_rvalid completes the request
//   sram_ce/_we/_addr/_wdata     SRAM macro control, word address and write data
//   sram_rdata                   SRAM read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module itcm_ctrl #(
    parameter int unsigned           ADDR_WIDTH    = 32,
    parameter int unsigned           DATA_WIDTH    = 32,
    parameter int unsigned           DEPTH_LOG2    = 12,
    parameter int unsigned           LOAD_WORDS    = 4096,
    parameter logic [ADDR_WIDTH-1:0] LOAD_SRC_BASE = 32'h0000_0000
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    input  logic                  instr_itcm_access,
    input  logic [ADDR_WIDTH-1:0] instr_itcm_addr,
    output logic [DATA_WIDTH-1:0] instr_itcm_read_data,
    output logic                  instr_itcm_read_data_valid,
    output logic                  itcm_auto_load,
    output logic                  ld_req,
    output logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_rdata,
    input  logic                  ld_rvalid,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [DEPTH_LOG2-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic                  w_in_load;     // FSM is in the LOAD state
    logic                  w_load_wr;     // load word arrives this cycle
    logic [DEPTH_LOG2-1:0] w_load_waddr;
    logic [DATA_WIDTH-1:0] w_load_wdata;
    logic                  w_accept;      // fetch read issued this cycle
    logic                  r_rvalid;

`ifdef KRV_ITCM_AUTO_LOAD_EN
    typedef enum logic {
        ST_LOAD,
        ST_SERVE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOAD_WORDS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the next-state default is assigned first so no path through the
    // case leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD:  if (ld_rvalid && (r_cnt == LAST_CNT)) w_state_nxt = ST_SERVE;
            default:  w_state_nxt = ST_SERVE;   // SERVE is terminal until reset
        endcase
    end

    // Stops at LAST_CNT; the FSM leaves LOAD on that word, so cnt never wraps.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_cnt <= '0;
        end else if (w_load_wr && (r_cnt != LAST_CNT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_in_load      = (r_state == ST_LOAD);
    // cpu_rstn gating keeps the SRAM quiet while reset is asserted.
    assign w_load_wr      = w_in_load & ld_rvalid & cpu_rstn;
    assign w_load_waddr   = r_cnt[DEPTH_LOG2-1:0];
    assign w_load_wdata   = ld_rdata;
    assign itcm_auto_load = w_in_load;
    assign ld_req         = w_in_load;
    assign ld_addr        = w_in_load ? (LOAD_SRC_BASE + ADDR_WIDTH'({r_cnt, 2'b00})) : '0;
`else
    logic w_unused_ld;

    assign w_in_load      = 1'b0;
    assign w_load_wr      = 1'b0;
    assign w_load_waddr   = '0;
    assign w_load_wdata   = '0;
    assign itcm_auto_load = 1'b0;
    assign ld_req         = 1'b0;
    assign ld_addr        = '0;
    assign w_unused_ld    = ^{ld_rdata, ld_rvalid, LOAD_SRC_BASE, 32'(LOAD_WORDS), CNT_W[0]};
`endif

    // Byte-offset bits and bits above the ITCM range carry no meaning here.
    logic w_unused_addr;
    assign w_unused_addr = ^{instr_itcm_addr[ADDR_WIDTH-1:DEPTH_LOG2+2], instr_itcm_addr[1:0]};

    assign w_accept = ~w_in_load & instr_itcm_access & cpu_rstn;

    // The load write and a fetch read can never coincide, since fetches are
    // only accepted outside LOAD.
    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (w_load_wr) begin
            sram_ce    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = w_load_waddr;
            sram_wdata = w_load_wdata;
        end else if (w_accept) begin
            sram_ce    = 1'b1;
            sram_addr  = instr_itcm_addr[DEPTH_LOG2+1:2];
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_accept;
        end
    end

    assign instr_itcm_read_data_valid = r_rvalid;
    assign instr_itcm_read_data       = r_rvalid ? sram_rdata : '0;

endmodule
